// File: rtl/data_mem_ctrl_if.sv
// CPU memory-stage bus: request/write fields from the master, read data and stall back from the slave.
interface data_mem_ctrl_if;
   logic        mem_ce;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_req;

   modport master (
      output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
      input  mem_rdata, stall_req
   );

   modport slave (
      input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
      output mem_rdata, stall_req
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte-lane writes and a fixed number of stall cycles per access.
module data_mem_ctrl #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   data_mem_ctrl_if.slave        mem_if
);

   localparam int          DEPTH     = 1 << ADDR_W;
   localparam bit          ZERO_WAIT = (WAIT == 0);
   localparam logic [3:0]  CNT_LOAD  = 4'(ZERO_WAIT ? 0 : WAIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   typedef logic [ADDR_W-1:0] idx_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   idx_t        idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;

   logic        stall;
   logic [31:0] rdata;
   logic        wr_en;
   idx_t        wr_idx;
   logic [3:0]  wr_sel;
   logic [31:0] wr_data;
   idx_t        req_idx;

   // NOTE: the array has no reset; contents are undefined until written, which lets it map onto RAM.
   logic [31:0] mem_q [0:DEPTH-1];

   assign req_idx = mem_if.mem_addr[ADDR_W+1:2];

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      stall   = 1'b0;
      rdata   = '0;
      wr_en   = 1'b0;
      wr_idx  = req_idx;
      wr_sel  = mem_if.mem_sel;
      wr_data = mem_if.mem_wdata;

      unique case (state_q)
         S_IDLE: begin
            if (mem_if.mem_ce) begin
               if (ZERO_WAIT) begin
                  if (mem_if.mem_we) wr_en = 1'b1;
                  else               rdata = mem_q[req_idx];
               end else begin
                  stall   = 1'b1;
                  we_d    = mem_if.mem_we;
                  sel_d   = mem_if.mem_sel;
                  idx_d   = req_idx;
                  wdata_d = mem_if.mem_wdata;
                  cnt_d   = CNT_LOAD;
                  state_d = (WAIT == 1) ? S_DONE : S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // The IDLE cycle already stalled once, so leave when the count decrements to zero.
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_DONE;
         end
         S_DONE: begin
            wr_idx  = idx_q;
            wr_sel  = sel_q;
            wr_data = wdata_q;
            if (we_q) wr_en = 1'b1;
            else      rdata = mem_q[idx_q];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset silences the outputs and blocks any commit without waiting for a clock edge.
      if (rst) begin
         stall = 1'b0;
         rdata = '0;
         wr_en = 1'b0;
      end
   end

   assign mem_if.stall_req = stall;
   assign mem_if.mem_rdata = rdata;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_sel[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one instance each at WAIT=0, WAIT=3 and WAIT=2, checked with immediate assertions.
module tb_data_mem_ctrl;

   logic clk = 1'b0;
   logic rst0, rst3, rst2;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   data_mem_ctrl_if if0 ();
   data_mem_ctrl_if if3 ();
   data_mem_ctrl_if if2 ();

   data_mem_ctrl #(.ADDR_W(10), .WAIT(0)) u_w0 (.clk(clk), .rst(rst0), .mem_if(if0));
   data_mem_ctrl #(.ADDR_W(10), .WAIT(3)) u_w3 (.clk(clk), .rst(rst3), .mem_if(if3));
   data_mem_ctrl #(.ADDR_W(10), .WAIT(2)) u_w2 (.clk(clk), .rst(rst2), .mem_if(if2));

   typedef struct packed {
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_stall;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } step_t;

   step_t b2b [13];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic ce, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
      if0.mem_ce = ce; if0.mem_we = we; if0.mem_sel = sel;
      if0.mem_addr = addr; if0.mem_wdata = wdata;
      #1;
   endtask

   // One stalled access on the WAIT=3 instance; returns stall-cycle count and DONE-cycle read data.
   task automatic acc3(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, output int stalls, output logic [31:0] done_rd);
      stalls  = 0;
      done_rd = 'x;
      tick();
      if3.mem_ce = 1'b1; if3.mem_we = we; if3.mem_sel = sel;
      if3.mem_addr = addr; if3.mem_wdata = wdata;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (if3.stall_req !== 1'b1) begin
            done_rd = if3.mem_rdata;
            break;
         end
         stalls++;
         if (i > 0) check("w3_wait_rdata", if3.mem_rdata, 32'h0);
         tick();
         if3.mem_ce = 1'b0;
         #1;
      end
      tick();
   endtask

   initial begin
      int          stalls;
      logic [31:0] rd;

      rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
      if0.mem_ce = 0; if0.mem_we = 0; if0.mem_sel = 0; if0.mem_addr = 0; if0.mem_wdata = 0;
      if3.mem_ce = 0; if3.mem_we = 0; if3.mem_sel = 0; if3.mem_addr = 0; if3.mem_wdata = 0;
      if2.mem_ce = 0; if2.mem_we = 0; if2.mem_sel = 0; if2.mem_addr = 0; if2.mem_wdata = 0;

      // Reset state, including a request held while reset is high
      #3;
      check("rst_w0_stall", 32'(if0.stall_req), 32'h0);
      check("rst_w0_rdata", if0.mem_rdata, 32'h0);
      check("rst_w2_stall", 32'(if2.stall_req), 32'h0);
      if3.mem_ce = 1'b1;
      #1;
      check("rst_w3_req_stall", 32'(if3.stall_req), 32'h0);
      check("rst_w3_req_rdata", if3.mem_rdata, 32'h0);
      if3.mem_ce = 1'b0;
      tick();
      rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;

      // WAIT=0: full-word write then read
      tick(); drv0(1, 1, 4'b1111, 32'h10, 32'hDEADBEEF);
      check("w0_wr_stall", 32'(if0.stall_req), 32'h0);
      check("w0_wr_rdata", if0.mem_rdata, 32'h0);
      tick(); drv0(1, 0, 4'b0000, 32'h10, 32'h0);
      check("w0_rd_full", if0.mem_rdata, 32'hDEADBEEF);
      check("w0_rd_stall", 32'(if0.stall_req), 32'h0);

      // Byte-lane merge and a no-lane write
      tick(); drv0(1, 1, 4'b0010, 32'h10, 32'h0000AA00);
      tick(); drv0(1, 0, 4'b0001, 32'h10, 32'h0);
      check("w0_rd_merge", if0.mem_rdata, 32'hDEADAAEF);
      tick(); drv0(1, 1, 4'b0000, 32'h10, 32'hFFFFFFFF);
      check("w0_sel0_rdata", if0.mem_rdata, 32'h0);
      tick(); drv0(1, 0, 4'b0000, 32'h10, 32'h0);
      check("w0_rd_after_sel0", if0.mem_rdata, 32'hDEADAAEF);

      // Address aliasing: 0x1003 maps to word 0
      tick(); drv0(1, 1, 4'b1111, 32'h1003, 32'hCAFEF00D);
      tick(); drv0(1, 0, 4'b0000, 32'h0000, 32'h0);
      check("w0_rd_alias", if0.mem_rdata, 32'hCAFEF00D);
      tick(); drv0(1, 0, 4'b0000, 32'h10, 32'h0);
      check("w0_rd_alias_other", if0.mem_rdata, 32'hDEADAAEF);
      tick(); drv0(0, 0, 4'b0000, 32'h10, 32'h0);
      check("w0_idle_rdata", if0.mem_rdata, 32'h0);
      check("w0_idle_stall", 32'(if0.stall_req), 32'h0);

      // WAIT=3: preload, stalled read
      acc3(1, 4'b1111, 32'h10, 32'hDEADAAEF, stalls, rd);
      check("w3_wr_stalls", 32'(stalls), 32'd3);
      check("w3_wr_done_rdata", rd, 32'h0);
      acc3(0, 4'b0000, 32'h10, 32'h0, stalls, rd);
      check("w3_rd_stalls", 32'(stalls), 32'd3);
      check("w3_rd_done_rdata", rd, 32'hDEADAAEF);

      // WAIT=3: reset in the second WAIT cycle discards the write
      tick();
      if3.mem_ce = 1'b1; if3.mem_we = 1'b1; if3.mem_sel = 4'b1111;
      if3.mem_addr = 32'h10; if3.mem_wdata = 32'h12345678;
      #1;
      check("w3_abort_idle_stall", 32'(if3.stall_req), 32'h1);
      tick(); if3.mem_ce = 1'b0;
      tick();
      check("w3_abort_wait2_stall", 32'(if3.stall_req), 32'h1);
      rst3 = 1'b1;
      #1;
      check("w3_abort_rst_stall", 32'(if3.stall_req), 32'h0);
      check("w3_abort_rst_rdata", if3.mem_rdata, 32'h0);
      tick(); tick();
      rst3 = 1'b0;
      acc3(0, 4'b0000, 32'h10, 32'h0, stalls, rd);
      check("w3_abort_rd_stalls", 32'(stalls), 32'd3);
      check("w3_abort_rd_data", rd, 32'hDEADAAEF);

      // WAIT=2: back-to-back write, read, write, read with no bubbles
      b2b[0]  = '{1'b1, 1'b1, 32'h20, 32'h0BADF00D, 1'b1, 1'b0, 32'h0};
      b2b[1]  = '{1'b1, 1'b1, 32'h20, 32'h0BADF00D, 1'b1, 1'b1, 32'h0};
      b2b[2]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b1, 32'h0};
      b2b[3]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h0};
      b2b[4]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h0};
      b2b[5]  = '{1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h0BADF00D};
      b2b[6]  = '{1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0};
      b2b[7]  = '{1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h0};
      b2b[8]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b1, 32'h0};
      b2b[9]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h0};
      b2b[10] = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h0};
      b2b[11] = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
      b2b[12] = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 1'b1, 32'h0};
      for (int i = 0; i < 13; i++) begin
         tick();
         if2.mem_ce = b2b[i].ce; if2.mem_we = b2b[i].we; if2.mem_sel = 4'b1111;
         if2.mem_addr = b2b[i].addr; if2.mem_wdata = b2b[i].wdata;
         #1;
         check($sformatf("w2_b2b_stall_%0d", i), 32'(if2.stall_req), 32'(b2b[i].exp_stall));
         if (b2b[i].chk_rd)
            check($sformatf("w2_b2b_rdata_%0d", i), if2.mem_rdata, b2b[i].exp_rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width; the internal array holds 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT, default 2: stall cycles per access; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_ce  input  1  access request from the CPU memory stage.
REQ-006 mem_we  input  1  1 = write, 0 = read; qualified by mem_ce.
REQ-007 mem_sel  input  4  byte-lane enables; sel[3] = bits 31:24, down to sel[0] = bits 7:0.
REQ-008 mem_addr  input  32  byte address.
REQ-009 mem_wdata  input  32  write data, lane-aligned.
REQ-010 mem_rdata  output  32  read data to the CPU memory stage.
REQ-011 stall_req  output  1  pause request to the pipeline control block.

Function
REQ-012 The word index SHALL be mem_addr[ADDR_W+1:2]; mem_addr[1:0] and the bits above ADDR_W+1 are ignored, so upper addresses alias.
REQ-013 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-014 IDLE with mem_ce=0: stall_req=0, mem_rdata=0, no array change.
REQ-015 IDLE with mem_ce=1 and WAIT=0: zero-latency access; stall_req=0; a read drives mem_rdata=array[index] combinationally; a write commits at the next rising edge; state stays IDLE.
REQ-016 IDLE with mem_ce=1 and WAIT>0: stall_req=1 combinationally in the same cycle.
REQ-017 At the edge that leaves IDLE (REQ-016 case): latch we, sel, index and wdata; load counter=WAIT-1; go to WAIT, or directly to DONE if WAIT=1.
REQ-018 WAIT state: stall_req=1 and mem_rdata=0; all mem_* inputs ignored; counter decrements each edge; the edge with counter=0 moves to DONE.
REQ-019 Total stall_req-high cycles per access SHALL equal WAIT exactly.
REQ-020 DONE state: stall_req=0; a latched read drives mem_rdata=array[latched index]; a latched write drives mem_rdata=0 and commits at the edge leaving DONE; the next state is always IDLE.
REQ-021 Back-to-back accesses: the request presented in the cycle after DONE SHALL be accepted in IDLE without an extra bubble.
REQ-022 Write merge: only lanes with sel=1 are updated, the others keep their old bytes; a write with sel=0000 changes nothing.
REQ-023 Reads SHALL return the full 32-bit word regardless of sel; lane extraction belongs to the CPU memory stage.
REQ-024 During a WAIT=0 write, mem_rdata SHALL be 0.
REQ-025 A read of an index in the same cycle as its WAIT=0 write SHALL return the pre-write value.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, stall_req=0 and mem_rdata=0, and clear all latched request fields.
REQ-027 Reset during WAIT or DONE SHALL discard the pending write, so the array is not modified.
REQ-028 Array contents are not initialised by reset; the bench writes before it reads.

Verification
REQ-029 Full-word write then read (WAIT=0): write 0xDEADBEEF, sel=1111, addr 0x10; then read 0x10 -> mem_rdata=0xDEADBEEF, stall_req stays 0 throughout.
REQ-030 Byte-lane merge: write 0x0000AA00, sel=0010, to 0x10; then read 0x10 -> 0xDEADAAEF; a following write with sel=0000 leaves 0xDEADAAEF.
REQ-031 Stalled read (WAIT=3): read 0x10 -> stall_req high exactly 3 cycles, then DONE cycle with stall_req=0 and mem_rdata=0xDEADAAEF.
REQ-032 Reset mid-access (WAIT=3): write 0x12345678 to 0x10, assert rst in the second WAIT cycle -> stall_req=0 at once; a later read of 0x10 -> 0xDEADAAEF.
REQ-033 Address aliasing (ADDR_W=10): write 0xCAFEF00D to 0x1003 (addr[1:0]=11); then read 0x0000 -> 0xCAFEF00D.
REQ-034 Back-to-back (WAIT=2): read then write on consecutive requests -> stall pattern 1,1,0,1,1,0; the write commits at the final edge.
